// File: rtl/pipelined_adder_if.sv
// Stream interface for pipelined_adder: operand beat in, result beat out.
// The master is the environment; the slave is the adder.
interface pipelined_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, res, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, res, cout, ovf, zero
   );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor with a valid/ready stream on
// both sides. The carry chain is cut into STAGES slices of SW = WIDTH/STAGES
// bits; each slice adds in its own stage and registers its carry. Operand
// slices not yet consumed ride along in skew registers, finished result
// slices ride along in deskew registers, so every stage register is exactly
// as wide as it needs to be.
//
// Optional feature: define PIPELINED_ADDER_SAT_EN to clamp the result to the
// signed limit on overflow (clamp sits in the final stage, no extra latency).
//
// WIDTH must be a multiple of STAGES, STAGES >= 1.
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   pipelined_adder_if.slave bus
);

   localparam int SW = WIDTH / STAGES;

   logic              adv;
   logic [WIDTH-1:0]  b_eff;
   logic              cin_eff;
   logic [STAGES-1:0] vld;

   // Whole pipeline moves together; it only stops when a result is stuck.
   assign adv           = !vld[STAGES-1] || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = vld[STAGES-1];

   // Subtraction is a + ~b + 1, so the carry-in is forced and cin ignored.
   assign b_eff   = bus.sub ? ~bus.b : bus.b;
   assign cin_eff = bus.sub ? 1'b1 : bus.cin;

   // Valid bits shift with the data; bubbles travel as zeros.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
      end else if (adv) begin
         vld[0] <= bus.in_valid;
         for (int i = 1; i < STAGES; i++) begin
            vld[i] <= vld[i-1];
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SW-1:0] a_sl;
      logic [SW-1:0] b_sl;
      logic          c_in;
      logic [SW:0]   sum;

      // Stage 0 reads the ports; later stages read the previous stage's
      // skew registers and registered carry.
      if (k == 0) begin : g_src
         assign a_sl = bus.a[SW-1:0];
         assign b_sl = b_eff[SW-1:0];
         assign c_in = cin_eff;
      end else begin : g_src
         assign a_sl = g_stage[k-1].g_mid.a_hi[SW-1:0];
         assign b_sl = g_stage[k-1].g_mid.b_hi[SW-1:0];
         assign c_in = g_stage[k-1].g_mid.cy;
      end

      // Slice add is SW+1 bits wide so the carry is never lost.
      assign sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SW{1'b0}}, c_in};

      if (k < STAGES-1) begin : g_mid
         localparam int OW = (STAGES-1-k)*SW;

         logic                  cy;
         logic [(k+1)*SW-1:0]   acc;
         logic [OW-1:0]         a_hi;
         logic [OW-1:0]         b_hi;
         logic [(k+1)*SW-1:0]   acc_d;
         logic [OW-1:0]         a_hi_d;
         logic [OW-1:0]         b_hi_d;

         if (k == 0) begin : g_feed
            assign acc_d  = sum[SW-1:0];
            assign a_hi_d = bus.a[WIDTH-1:SW];
            assign b_hi_d = b_eff[WIDTH-1:SW];
         end else begin : g_feed
            assign acc_d  = {sum[SW-1:0], g_stage[k-1].g_mid.acc};
            assign a_hi_d = g_stage[k-1].g_mid.a_hi[OW+SW-1:SW];
            assign b_hi_d = g_stage[k-1].g_mid.b_hi[OW+SW-1:SW];
         end

         // Register carry, finished low result slices and pending operand slices.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cy   <= 1'b0;
               acc  <= '0;
               a_hi <= '0;
               b_hi <= '0;
            end else if (adv) begin
               cy   <= sum[SW];
               acc  <= acc_d;
               a_hi <= a_hi_d;
               b_hi <= b_hi_d;
            end
         end
      end else begin : g_last
         logic [WIDTH-1:0] raw;
         logic [WIDTH-1:0] res_c;
         logic             ovf_c;
         logic             zero_c;
         logic [WIDTH-1:0] res_q;
         logic             cout_q;
         logic             ovf_q;
         logic             zero_q;

         if (k == 0) begin : g_raw
            assign raw = sum[SW-1:0];
         end else begin : g_raw
            assign raw = {sum[SW-1:0], g_stage[k-1].g_mid.acc};
         end

         // Top slice holds both operand sign bits, so overflow is decided here.
         assign ovf_c = (a_sl[SW-1] == b_sl[SW-1]) && (raw[WIDTH-1] != a_sl[SW-1]);

`ifdef PIPELINED_ADDER_SAT_EN
         // Clamp toward the sign of a: positive overflow -> max, negative -> min.
         always_comb begin
            res_c = raw;
            if (ovf_c) begin
               res_c = a_sl[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
            end
         end
`else
         assign res_c = raw;
`endif

         assign zero_c = (res_c == '0);

         // Output register: result and flags move as one beat.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               res_q  <= '0;
               cout_q <= 1'b0;
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (adv) begin
               res_q  <= res_c;
               cout_q <= sum[SW];
               ovf_q  <= ovf_c;
               zero_q <= zero_c;
            end
         end

         assign bus.res  = res_q;
         assign bus.cout = cout_q;
         assign bus.ovf  = ovf_q;
         assign bus.zero = zero_q;
      end
   end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder, WIDTH=32, STAGES=4.
module tb_pipelined_adder;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   pipelined_adder_if #(.WIDTH(32)) bus ();

   pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one beat from a negedge and return the first valid result.
   task automatic run_beat(input logic [31:0] ta, input logic [31:0] tb_v,
                           input logic tc, input logic ts,
                           output logic [31:0] r, output logic c,
                           output logic o, output logic z, output int lat);
      bus.in_valid  = 1'b1;
      bus.a         = ta;
      bus.b         = tb_v;
      bus.cin       = tc;
      bus.sub       = ts;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      r = bus.res;
      c = bus.cout;
      o = bus.ovf;
      z = bus.zero;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.res !== 32'h0) begin n_bad++; $display("FAIL rst_res: got %h want 00000000", bus.res); end
      n_cmp++; if (bus.cout !== 1'b0) begin n_bad++; $display("FAIL rst_cout: got %b want 0", bus.cout); end
      n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", bus.ovf); end
      n_cmp++; if (bus.zero !== 1'b0) begin n_bad++; $display("FAIL rst_zero: got %b want 0", bus.zero); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL idle_in_ready: got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_out_valid: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_carry();
      logic [31:0] r; logic c, o, z; int lat;
      run_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r, c, o, z, lat);
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL carry_latency: got %0d want 4", lat); end
      n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL carry_res: got %h want 00000000", r); end
      n_cmp++; if (c !== 1'b1) begin n_bad++; $display("FAIL carry_cout: got %b want 1", c); end
      n_cmp++; if (z !== 1'b1) begin n_bad++; $display("FAIL carry_zero: got %b want 1", z); end
      n_cmp++; if (o !== 1'b0) begin n_bad++; $display("FAIL carry_ovf: got %b want 0", o); end
      @(negedge clk);
      run_beat(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, r, c, o, z, lat);
      n_cmp++; if (r !== 32'h0001_0000) begin n_bad++; $display("FAIL cin_res: got %h want 00010000", r); end
      n_cmp++; if (c !== 1'b0) begin n_bad++; $display("FAIL cin_cout: got %b want 0", c); end
      @(negedge clk);
   endtask

   task automatic test_sub();
      logic [31:0] r; logic c, o, z; int lat;
      for (int ci = 0; ci < 2; ci++) begin
         run_beat(32'd5, 32'd7, ci[0], 1'b1, r, c, o, z, lat);
         n_cmp++; if (r !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL sub_res cin=%0d: got %h want fffffffe", ci, r); end
         n_cmp++; if (c !== 1'b0) begin n_bad++; $display("FAIL sub_cout cin=%0d: got %b want 0", ci, c); end
         n_cmp++; if (o !== 1'b0) begin n_bad++; $display("FAIL sub_ovf cin=%0d: got %b want 0", ci, o); end
         n_cmp++; if (z !== 1'b0) begin n_bad++; $display("FAIL sub_zero cin=%0d: got %b want 0", ci, z); end
         @(negedge clk);
      end
      run_beat(32'd9, 32'd9, 1'b0, 1'b1, r, c, o, z, lat);
      n_cmp++; if (r !== 32'h0 || z !== 1'b1 || c !== 1'b1) begin n_bad++; $display("FAIL sub_equal: got res=%h zero=%b cout=%b want 0/1/1", r, z, c); end
      @(negedge clk);
   endtask

   task automatic test_overflow();
      logic [31:0] r; logic c, o, z; int lat;
      logic [31:0] exp_pos; logic [31:0] exp_neg; logic exp_nz;
`ifdef PIPELINED_ADDER_SAT_EN
      exp_pos = 32'h7FFF_FFFF; exp_neg = 32'h8000_0000; exp_nz = 1'b0;
`else
      exp_pos = 32'h8000_0000; exp_neg = 32'h0000_0000; exp_nz = 1'b1;
`endif
      run_beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r, c, o, z, lat);
      n_cmp++; if (o !== 1'b1) begin n_bad++; $display("FAIL povf_ovf: got %b want 1", o); end
      n_cmp++; if (r !== exp_pos) begin n_bad++; $display("FAIL povf_res: got %h want %h", r, exp_pos); end
      n_cmp++; if (c !== 1'b0 || z !== 1'b0) begin n_bad++; $display("FAIL povf_flags: got cout=%b zero=%b want 0/0", c, z); end
      @(negedge clk);
      run_beat(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, r, c, o, z, lat);
      n_cmp++; if (o !== 1'b1) begin n_bad++; $display("FAIL novf_ovf: got %b want 1", o); end
      n_cmp++; if (r !== exp_neg) begin n_bad++; $display("FAIL novf_res: got %h want %h", r, exp_neg); end
      n_cmp++; if (c !== 1'b1) begin n_bad++; $display("FAIL novf_cout: got %b want 1", c); end
      n_cmp++; if (z !== exp_nz) begin n_bad++; $display("FAIL novf_zero: got %b want %b", z, exp_nz); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int sent, rcvd, cyc;
      logic [31:0] held;
      logic was_stall, push, pop, seen;
      logic [0:3] pat;
      pat = 4'b1001;
      sent = 0; rcvd = 0; was_stall = 1'b0; held = '0;
      bus.cin = 1'b0; bus.sub = 1'b0;
      for (cyc = 0; cyc < 200 && rcvd < 8; cyc++) begin
         bus.out_ready = pat[cyc % 4];
         bus.in_valid  = (sent < 8);
         bus.a         = sent;
         bus.b         = 32'(100 * sent);
         #1;
         push = bus.in_valid && bus.in_ready;
         pop  = bus.out_valid && bus.out_ready;
         if (pop) begin
            n_cmp++; if (bus.res !== 32'(101 * rcvd)) begin n_bad++; $display("FAIL stream_res[%0d]: got %0d want %0d", rcvd, bus.res, 101 * rcvd); end
            rcvd++;
         end
         if (bus.out_valid && !bus.out_ready) begin
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready); end
            if (was_stall) begin
               n_cmp++; if (bus.res !== held) begin n_bad++; $display("FAIL stall_hold: got %h want %h", bus.res, held); end
            end
            held = bus.res;
            was_stall = 1'b1;
         end else begin
            was_stall = 1'b0;
         end
         @(posedge clk);
         if (push) sent++;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      n_cmp++; if (rcvd !== 8) begin n_bad++; $display("FAIL stream_count: got %0d want 8", rcvd); end
      n_cmp++; if (sent !== 8) begin n_bad++; $display("FAIL stream_sent: got %0d want 8", sent); end
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL stream_extra: got out_valid=%b want 0", seen); end
   endtask

   task automatic test_reset_midflight();
      logic [31:0] r; logic c, o, z, seen; int lat;
      bus.out_ready = 1'b1;
      bus.cin = 1'b0; bus.sub = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.a = 32'(i + 1);
         bus.b = 32'd1;
         @(posedge clk);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_during: got %b want 0", bus.out_valid); end
      rst = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_after: got out_valid=%b want 0", seen); end
      run_beat(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, r, c, o, z, lat);
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL midrst_latency: got %0d want 4", lat); end
      n_cmp++; if (r !== 32'h2345_6789) begin n_bad++; $display("FAIL midrst_res: got %h want 23456789", r); end
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b1;
      test_reset();
      test_carry();
      test_sub();
      test_overflow();
      test_back_to_back();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
